// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a simple dual-port RAM
// with a registered read port; out-of-range accesses are dropped with err.
module ram_arbiter #(
    parameter int k = 8,
    parameter int l = 64,
    parameter int m = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_req,
    input  logic         a_we,
    input  logic [m-1:0] a_adr,
    input  logic [k-1:0] a_wdata,
    input  logic         b_req,
    input  logic         b_we,
    input  logic [m-1:0] b_adr,
    input  logic [k-1:0] b_wdata,
    output logic         a_gnt,
    output logic         a_err,
    output logic         a_rvalid,
    output logic [k-1:0] a_rdata,
    output logic         b_gnt,
    output logic         b_err,
    output logic         b_rvalid,
    output logic [k-1:0] b_rdata,
    output logic         ram_we,
    output logic [m-1:0] ram_write_adr,
    output logic [m-1:0] ram_read_adr,
    output logic [k-1:0] ram_data_in,
    input  logic [k-1:0] ram_data_out
);

    localparam logic [m:0] LIM = (m+1)'(l);

    logic         prio;
    logic         rtag_v;
    logic         rtag_id;
    logic         sel_a;
    logic         sel_b;
    logic         any;
    logic         we;
    logic         inr;
    logic         wr_ok;
    logic         rd_ok;
    logic [m-1:0] adr;
    logic [k-1:0] wdata;

    // prio names the preferred requester when both ask at once
    always_comb begin
        sel_a = 1'b0;
        sel_b = 1'b0;
        if (rst_n) begin
            sel_a = a_req & (~b_req | ~prio);
            sel_b = b_req & (~a_req | prio);
        end
    end

    assign any   = sel_a | sel_b;
    assign adr   = sel_b ? b_adr : a_adr;
    assign we    = sel_b ? b_we : a_we;
    assign wdata = sel_b ? b_wdata : a_wdata;
    assign inr   = {1'b0, adr} < LIM;
    assign wr_ok = any & we & inr;
    assign rd_ok = any & ~we & inr;

    assign a_gnt = sel_a;
    assign b_gnt = sel_b;
    assign a_err = sel_a & ~inr;
    assign b_err = sel_b & ~inr;

    assign ram_we        = wr_ok;
    assign ram_write_adr = wr_ok ? adr : '0;
    assign ram_data_in   = wr_ok ? wdata : '0;
    assign ram_read_adr  = rd_ok ? adr : '0;

    assign a_rvalid = rtag_v & ~rtag_id;
    assign b_rvalid = rtag_v & rtag_id;
    assign a_rdata  = ram_data_out;
    assign b_rdata  = ram_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            rtag_v  <= 1'b0;
            rtag_id <= 1'b0;
        end else begin
            if (any) prio <= sel_a;
            rtag_v <= rd_ok;
            if (rd_ok) rtag_id <= sel_b;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [6:0] a_adr, b_adr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_err, a_rvalid, b_gnt, b_err, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_we;
    logic [6:0] ram_write_adr, ram_read_adr;
    logic [7:0] ram_data_in, ram_data_out;
    logic [7:0] mem [0:63];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.k(8), .l(64), .m(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_err(a_err), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_err(b_err), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_write_adr(ram_write_adr),
        .ram_read_adr(ram_read_adr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_write_adr[5:0]] <= ram_data_in;
        ram_data_out <= mem[ram_read_adr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_a(input logic r, input logic w,
                         input logic [6:0] ad, input logic [7:0] d);
        a_req = r; a_we = w; a_adr = ad; a_wdata = d;
    endtask

    task automatic drv_b(input logic r, input logic w,
                         input logic [6:0] ad, input logic [7:0] d);
        b_req = r; b_we = w; b_adr = ad; b_wdata = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 3 + 1);
        rst_n = 1'b0;
        drv_a(1, 1, 7'd5, 8'h11);
        drv_b(1, 1, 7'd6, 8'h22);
        mid();
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_wadr", ram_write_adr, 0);
        check("rst_din", ram_data_in, 0);
        step();
        rst_n = 1'b1;
        drv_a(0, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        mid();
        check("post_rst_a_rv", a_rvalid, 0);
        check("post_rst_b_rv", b_rvalid, 0);
        check("idle_radr", ram_read_adr, 0);

        // contention from reset: A,B,A,B
        step();
        drv_a(1, 0, 7'd20, 0);
        drv_b(1, 0, 7'd40, 0);
        mid();
        check("c0_a_gnt", a_gnt, 1);
        check("c0_b_gnt", b_gnt, 0);
        check("c0_radr", ram_read_adr, 20);
        step(); mid();
        check("c1_b_gnt", b_gnt, 1);
        check("c1_a_gnt", a_gnt, 0);
        check("c1_a_rv", a_rvalid, 1);
        check("c1_a_rd", a_rdata, 8'h3D);
        step(); mid();
        check("c2_a_gnt", a_gnt, 1);
        check("c2_b_rv", b_rvalid, 1);
        check("c2_a_rv", a_rvalid, 0);
        check("c2_b_rd", b_rdata, 8'h79);
        step(); mid();
        check("c3_b_gnt", b_gnt, 1);
        check("c3_a_rv", a_rvalid, 1);
        check("c3_a_rd", a_rdata, 8'h3D);
        step();
        drv_a(0, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        mid();
        check("c4_b_rv", b_rvalid, 1);
        check("c4_b_rd", b_rdata, 8'h79);

        // A write then read same address
        step();
        drv_a(1, 1, 7'd3, 8'h5A);
        mid();
        check("w3_gnt", a_gnt, 1);
        check("w3_we", ram_we, 1);
        check("w3_adr", ram_write_adr, 3);
        check("w3_din", ram_data_in, 8'h5A);
        check("w3_b_rv", b_rvalid, 0);
        step();
        drv_a(1, 0, 7'd3, 0);
        mid();
        check("r3_gnt", a_gnt, 1);
        check("r3_we", ram_we, 0);
        check("r3_radr", ram_read_adr, 3);
        check("r3_a_rv_early", a_rvalid, 0);
        step();
        drv_a(0, 0, 0, 0);
        mid();
        check("r3_a_rv", a_rvalid, 1);
        check("r3_a_rd", a_rdata, 8'h5A);
        check("r3_b_rv", b_rvalid, 0);

        // B write, A read next cycle
        step();
        drv_b(1, 1, 7'd10, 8'hC3);
        mid();
        check("bw10_gnt", b_gnt, 1);
        check("bw10_we", ram_we, 1);
        step();
        drv_b(0, 0, 0, 0);
        drv_a(1, 0, 7'd10, 0);
        mid();
        check("ar10_gnt", a_gnt, 1);
        step();
        drv_a(0, 0, 0, 0);
        mid();
        check("ar10_rv", a_rvalid, 1);
        check("ar10_rd", a_rdata, 8'hC3);

        // out of range read hands the turn to B
        step();
        drv_a(1, 0, 7'd64, 0);
        mid();
        check("oor_gnt", a_gnt, 1);
        check("oor_err", a_err, 1);
        check("oor_we", ram_we, 0);
        step();
        drv_a(1, 0, 7'd1, 0);
        drv_b(1, 0, 7'd2, 0);
        mid();
        check("oor_no_rv", a_rvalid, 0);
        check("oor_b_wins", b_gnt, 1);
        check("oor_a_loses", a_gnt, 0);
        check("oor_b_err", b_err, 0);
        step();
        drv_b(0, 0, 0, 0);
        mid();
        check("oor_b_rv", b_rvalid, 1);
        check("oor_b_rd", b_rdata, 8'h07);
        check("oor_a_gnt2", a_gnt, 1);
        step();
        drv_a(0, 0, 0, 0);
        mid();
        check("oor_a_rv", a_rvalid, 1);
        check("oor_a_rd", a_rdata, 8'h04);

        // reset during a read request
        step();
        rst_n = 1'b0;
        drv_a(1, 0, 7'd5, 0);
        mid();
        check("mrst_gnt", a_gnt, 0);
        check("mrst_err", a_err, 0);
        check("mrst_radr", ram_read_adr, 0);
        step();
        rst_n = 1'b1;
        drv_a(0, 0, 0, 0);
        mid();
        check("mrst_no_rv", a_rvalid, 0);
        step();
        drv_a(1, 0, 7'd6, 0);
        drv_b(1, 0, 7'd7, 0);
        mid();
        check("mrst_a_wins", a_gnt, 1);
        check("mrst_b_waits", b_gnt, 0);
        step();
        drv_a(0, 0, 0, 0);
        drv_b(0, 0, 0, 0);
        mid();
        check("mrst_a_rd", a_rdata, 8'h13);

        // burst writes then burst reads from A alone
        for (int i = 0; i < 5; i++) begin
            step();
            drv_a(1, 1, 7'(i), 8'(i + 1));
            mid();
            check("bw_gnt", a_gnt, 1);
            check("bw_adr", ram_write_adr, i);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            drv_a(1, 0, 7'(i), 0);
            mid();
            check("br_gnt", a_gnt, 1);
            if (i > 0) begin
                check("br_rv", a_rvalid, 1);
                check("br_rd", a_rdata, i);
            end
        end
        step();
        drv_a(0, 0, 0, 0);
        mid();
        check("br_last_rv", a_rvalid, 1);
        check("br_last_rd", a_rdata, 5);
        check("end_we", ram_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
